// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and types for the instruction-memory refill responder.
package inst_mem_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = ADDR_W - 2;

   // Filler returned for word indices beyond the backing store (addi x0,x0,0).
   localparam logic [DATA_W-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                         input int unsigned      depth);
      return 32'(idx) < depth;
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Backing instruction store: synchronous write, combinational read; not reset.
module inst_mem_array
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // Out-of-range writes are silently discarded.
   always_ff @(posedge clk) begin
      if (we_i && idx_in_range(wr_idx_i, DEPTH_WORDS)) begin
         mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
      end
   end

   assign rd_data_o = idx_in_range(rd_idx_i, DEPTH_WORDS) ? mem_q[rd_idx_i[AW-1:0]]
                                                          : NOP_INSN;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-cache refill responder: critical-word-first wrapping line bursts
// after a fixed latency, plus a program-load write port usable while idle.
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned LATENCY     = 3,
   parameter int unsigned DEPTH_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_last,
   input  logic              resp_ready,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ack
);

   localparam int unsigned      OFF_W     = $clog2(LINE_WORDS);
   localparam int unsigned      CNT_W     = 4;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

   state_e             state_q;
   logic [IDX_W-1:0]   addr_q;
   logic [OFF_W-1:0]   beat_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               resp_valid_q;
   beat_t              resp_q;
   logic               ld_ack_q;

   logic [OFF_W-1:0]   beat_next_c;
   logic [IDX_W-1:0]   rd_idx_c;
   logic [IDX_W-1:0]   ld_idx_c;
   logic               ld_commit_c;
   logic               fwd_hit_c;
   logic [DATA_W-1:0]  arr_rdata_c;
   logic [DATA_W-1:0]  beat_word_c;
   logic               unused_addr_bits_c;

   assign unused_addr_bits_c = ^{req_addr[1:0], ld_addr[1:0]};

   assign beat_next_c = beat_q + OFF_W'(1);
   assign ld_idx_c    = ld_addr[ADDR_W-1:2];
   assign ld_commit_c = ld_en && (state_q == ST_IDLE);

   // Word index of the beat being issued at the coming edge.
   always_comb begin
      rd_idx_c = req_addr[ADDR_W-1:2];
      case (state_q)
         ST_WAIT:  rd_idx_c = addr_q;
         ST_BURST: rd_idx_c = {addr_q[IDX_W-1:OFF_W], addr_q[OFF_W-1:0] + beat_next_c};
         default:  rd_idx_c = req_addr[ADDR_W-1:2];
      endcase
   end

   inst_mem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk      (clk),
      .we_i     (ld_commit_c),
      .wr_idx_i (ld_idx_c),
      .wr_data_i(ld_data),
      .rd_idx_i (rd_idx_c),
      .rd_data_o(arr_rdata_c)
   );

   // A load committing in the same edge a beat is issued must win (LATENCY=1).
   assign fwd_hit_c   = ld_commit_c && (ld_idx_c == rd_idx_c)
                        && idx_in_range(rd_idx_c, DEPTH_WORDS);
   assign beat_word_c = fwd_hit_c ? ld_data : arr_rdata_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         beat_q       <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
         ld_ack_q     <= 1'b0;
      end else begin
         ld_ack_q <= ld_commit_c;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr[ADDR_W-1:2];
                  beat_q <= '0;
                  if (LATENCY == 1) begin
                     state_q      <= ST_BURST;
                     resp_valid_q <= 1'b1;
                     resp_q       <= '{data: beat_word_c, last: 1'b0};
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q      <= ST_BURST;
                  resp_valid_q <= 1'b1;
                  resp_q       <= '{data: beat_word_c, last: 1'b0};
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_BURST: begin
               // Beat holds until consumed; the next one follows with no bubble.
               if (resp_ready) begin
                  if (resp_q.last) begin
                     state_q      <= ST_IDLE;
                     resp_valid_q <= 1'b0;
                     resp_q       <= '0;
                     beat_q       <= '0;
                  end else begin
                     beat_q <= beat_next_c;
                     resp_q <= '{data: beat_word_c, last: (beat_next_c == LAST_BEAT)};
                  end
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
               resp_q       <= '0;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_q.data;
   assign resp_last  = resp_q.last;
   assign ld_ack     = ld_ack_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder with default parameters.
module tb_inst_mem_responder;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int unsigned DEPTH = 16384;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_last;
   logic        resp_ready;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_ack;

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        exp_q[$];
   int          hs_q[$];
   logic [31:0] tb_mem [int];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inst_mem_responder #(
      .LINE_WORDS (4),
      .LATENCY    (3),
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .resp_last (resp_last),
      .resp_ready(resp_ready),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ack    (ld_ack)
   );

   function automatic logic [31:0] model_word(input int unsigned idx);
      if (idx >= DEPTH) return NOP;
      if (tb_mem.exists(int'(idx))) return tb_mem[int'(idx)];
      return 32'h0;
   endfunction

   function automatic void model_load(input logic [31:0] addr, input logic [31:0] data);
      int unsigned idx;
      idx = addr >> 2;
      if (idx < DEPTH) tb_mem[int'(idx)] = data;
   endfunction

   // Expected wrap order: word w first, then w+1.. modulo 4 within the aligned line.
   function automatic void push_line(input logic [31:0] addr);
      int unsigned w;
      int unsigned base;
      exp_t        e;
      w    = addr >> 2;
      base = w - (w % 4);
      for (int b = 0; b < 4; b++) begin
         e.data = model_word(base + ((w + b) % 4));
         e.last = (b == 3);
         exp_q.push_back(e);
      end
   endfunction

   // Advance one cycle; the scoreboard consumes handshakes at the falling edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
         hs_q.push_back(cyc);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected cyc=%0d: got data=%h last=%b, required no beat",
                     cyc, resp_data, resp_last);
         end else begin
            e = exp_q.pop_front();
            if ({resp_data, resp_last} !== {e.data, e.last}) begin
               bad++;
               $display("FAIL beat cyc=%0d: got data=%h last=%b, required data=%h last=%b",
                        cyc, resp_data, resp_last, e.data, e.last);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_req(input logic [31:0] addr, output int t);
      req_valid = 1'b1;
      req_addr  = addr;
      t         = cyc;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || resp_valid) && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      total++;
      if ({resp_valid, resp_last, ld_ack} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got valid=%b last=%b ack=%b, required 0 0 0",
                  resp_valid, resp_last, ld_ack);
      end
      total++;
      if (resp_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_data: got %h, required 00000000", resp_data);
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b, required 1", req_ready);
      end
      rst = 1'b0;
      tick();
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset: got ready=%b valid=%b, required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_load();
      for (int i = 0; i < 4; i++) begin
         ld_en   = 1'b1;
         ld_addr = 32'(4 * i);
         ld_data = 32'h1111_1111 * 32'(i + 1);
         model_load(ld_addr, ld_data);
         tick();
         ld_en = 1'b0;
         total++;
         if (ld_ack !== 1'b1) begin
            bad++;
            $display("FAIL load_ack_%0d: got %b, required 1", i, ld_ack);
         end
         tick();
         total++;
         if (ld_ack !== 1'b0) begin
            bad++;
            $display("FAIL load_ack_drop_%0d: got %b, required 0", i, ld_ack);
         end
      end
   endtask

   task automatic test_linear();
      int t;
      int got;
      push_line(32'h0);
      hs_q.delete();
      issue_req(32'h0, t);
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL linear_busy: got req_ready=%b, required 0", req_ready);
      end
      wait_done("linear");
      for (int b = 0; b < 4; b++) begin
         got = (b < hs_q.size()) ? hs_q[b] - t : -1;
         total++;
         if (got != 3 + b) begin
            bad++;
            $display("FAIL linear_timing_%0d: got T+%0d, required T+%0d", b, got, 3 + b);
         end
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL linear_idle: got req_ready=%b, required 1", req_ready);
      end
   endtask

   task automatic test_wrap();
      int t;
      push_line(32'h8);
      issue_req(32'h8, t);
      wait_done("wrap_8");
      push_line(32'h5);
      issue_req(32'h5, t);
      wait_done("wrap_5");
   endtask

   task automatic test_stall();
      int t;
      int got;
      logic [31:0] want;
      want = model_word(1);
      push_line(32'h0);
      hs_q.delete();
      issue_req(32'h0, t);
      while (cyc < t + 10) begin
         resp_ready = !(cyc == t + 4 || cyc == t + 5);
         if (cyc >= t + 4 && cyc <= t + 6) begin
            total++;
            if (resp_valid !== 1'b1 || resp_data !== want || resp_last !== 1'b0) begin
               bad++;
               $display("FAIL stall_hold T+%0d: got valid=%b data=%h last=%b, required 1 %h 0",
                        cyc - t, resp_valid, resp_data, resp_last, want);
            end
         end
         tick();
      end
      resp_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         got = (b < hs_q.size()) ? hs_q[b] - t : -1;
         total++;
         if (got != ((b == 0) ? 3 : 5 + b)) begin
            bad++;
            $display("FAIL stall_timing_%0d: got T+%0d, required T+%0d", b, got,
                     (b == 0) ? 3 : 5 + b);
         end
      end
      wait_done("stall");
   endtask

   task automatic test_oob();
      int t;
      push_line(32'h0001_0000);
      issue_req(32'h0001_0000, t);
      wait_done("oob_read");
      ld_en   = 1'b1;
      ld_addr = 32'h0001_0004;
      ld_data = 32'hCAFE_F00D;
      model_load(ld_addr, ld_data);
      tick();
      ld_en = 1'b0;
      total++;
      if (ld_ack !== 1'b1) begin
         bad++;
         $display("FAIL oob_ld_ack: got %b, required 1", ld_ack);
      end
      push_line(32'h0001_0004);
      issue_req(32'h0001_0004, t);
      wait_done("oob_after_load");
   endtask

   task automatic test_reset_mid();
      int t;
      int n;
      push_line(32'h0);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      issue_req(32'h0, t);
      while (cyc < t + 5) tick();
      rst = 1'b1;
      #1;
      total++;
      if ({resp_valid, resp_last} !== 2'b00 || resp_data !== 32'h0) begin
         bad++;
         $display("FAIL midrst_clear: got valid=%b last=%b data=%h, required 0 0 00000000",
                  resp_valid, resp_last, resp_data);
      end
      tick();
      tick();
      rst = 1'b0;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_ready: got %b, required 1", req_ready);
      end
      n = 0;
      repeat (6) begin
         if (resp_valid) n++;
         tick();
      end
      total++;
      if (n != 0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL midrst_no_beats: got %0d stray beats, %0d pending, required 0 0",
                  n, exp_q.size());
      end
      push_line(32'h0);
      issue_req(32'h0, t);
      wait_done("midrst_storage");
   endtask

   task automatic test_ld_burst();
      int t;
      push_line(32'h0);
      issue_req(32'h0, t);
      while (cyc < t + 4) tick();
      ld_en   = 1'b1;
      ld_addr = 32'h4;
      ld_data = 32'hDEAD_BEEF;
      tick();
      ld_en = 1'b0;
      total++;
      if (ld_ack !== 1'b0) begin
         bad++;
         $display("FAIL ld_in_burst_ack: got %b, required 0", ld_ack);
      end
      wait_done("ld_in_burst");
      model_load(32'h4, 32'hDEAD_BEEF);
      push_line(32'h0);
      ld_en     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      tick();
      ld_en     = 1'b0;
      req_valid = 1'b0;
      total++;
      if (ld_ack !== 1'b1) begin
         bad++;
         $display("FAIL ld_with_req_ack: got %b, required 1", ld_ack);
      end
      wait_done("ld_with_req");
   endtask

   task automatic test_back_to_back();
      int t;
      int got;
      push_line(32'h4);
      push_line(32'hC);
      hs_q.delete();
      req_valid = 1'b1;
      req_addr  = 32'h4;
      t         = cyc;
      tick();
      req_addr = 32'hC;
      while (cyc <= t + 7) tick();
      req_valid = 1'b0;
      wait_done("b2b");
      for (int b = 0; b < 8; b++) begin
         got = (b < hs_q.size()) ? hs_q[b] - t : -1;
         total++;
         if (got != ((b < 4) ? 3 + b : 6 + b)) begin
            bad++;
            $display("FAIL b2b_timing_%0d: got T+%0d, required T+%0d", b, got,
                     (b < 4) ? 3 + b : 6 + b);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      resp_ready = 1'b1;
      ld_en      = 1'b0;
      ld_addr    = 32'h0;
      ld_data    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load();
      test_linear();
      test_wrap();
      test_stall();
      test_oob();
      test_reset_mid();
      test_ld_burst();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
